testpattern_seq: RTL

Frame-synchronous configuration controller for the `testpattern` video generator. It holds shadow copies of every `testpattern` control input: timing, polarity, mode and single colour. These are written through a simple register port and committed to the active outputs only at a frame boundary, so the generator never sees a mid-frame change. It also validates each commit and, optionally, auto-cycles the pattern mode every N frames for soak and burn-in displays.

---
 rtl/testpattern_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/testpattern_seq.sv
// testpattern_seq: shadow/active configuration registers for the testpattern generator, committed at frame boundaries.
// Define TP_SEQ_AUTO_EN to compile in the frame counter that auto-steps the pattern mode every dwell frames.

module testpattern_seq (
    input  logic        I_pxl_clk,
    input  logic        I_rst,
    input  logic        I_vs,
    input  logic        I_wr_en,
    input  logic [3:0]  I_wr_addr,
    input  logic [11:0] I_wr_data,
    output logic        O_wr_ack,
    output logic [2:0]  O_mode,
    output logic [7:0]  O_single_r,
    output logic [7:0]  O_single_g,
    output logic [7:0]  O_single_b,
    output logic [11:0] O_h_total,
    output logic [11:0] O_h_sync,
    output logic [11:0] O_h_bporch,
    output logic [11:0] O_h_res,
    output logic [11:0] O_v_total,
    output logic [11:0] O_v_sync,
    output logic [11:0] O_v_bporch,
    output logic [11:0] O_v_res,
    output logic        O_hs_pol,
    output logic        O_vs_pol,
    output logic        O_commit_done,
    output logic        O_cfg_err,
    output logic        O_pending
);

    // state | meaning
    // RUN   | idle, active registers stable, waiting for a commit write
    // PEND  | commit requested, waiting for the next frame boundary
    // APPLY | one cycle: validate shadow set and copy it to active if legal
    typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_APPLY} state_t;
    state_t state;

    logic [11:0] sh_h_total, sh_h_sync, sh_h_bporch, sh_h_res;
    logic [11:0] sh_v_total, sh_v_sync, sh_v_bporch, sh_v_res;
    logic        sh_hs_pol, sh_vs_pol;
    logic [7:0]  sh_r, sh_g, sh_b;
    logic [2:0]  sh_mode;
`ifdef TP_SEQ_AUTO_EN
    logic        sh_auto_en, act_auto_en;
    logic [7:0]  sh_dwell, act_dwell, frame_cnt;
    logic        step_req;
    logic [2:0]  mode_next;
`endif

    logic        nv, s1, s2, frame_edge;
    logic [1:0]  mask_cnt;
    logic        commit_wr, cfg_ok;
    logic [12:0] h_sum, v_sum;

    assign nv        = I_vs ^ ~O_vs_pol;
    assign commit_wr = I_wr_en && (I_wr_addr == 4'hE) && I_wr_data[0];
    assign h_sum     = {1'b0, sh_h_sync} + {1'b0, sh_h_bporch} + {1'b0, sh_h_res};
    assign v_sum     = {1'b0, sh_v_sync} + {1'b0, sh_v_bporch} + {1'b0, sh_v_res};
    assign cfg_ok    = (h_sum <= {1'b0, sh_h_total}) && (v_sum <= {1'b0, sh_v_total}) &&
                       (sh_h_sync != 12'd0) && (sh_v_sync != 12'd0) &&
                       (sh_h_res != 12'd0) && (sh_v_res != 12'd0);
`ifdef TP_SEQ_AUTO_EN
    assign mode_next = (O_mode >= 3'd3) ? 3'd0 : O_mode + 3'd1;
`endif

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            state         <= ST_RUN;
            O_wr_ack      <= 1'b0;
            O_commit_done <= 1'b0;
            O_cfg_err     <= 1'b0;
            O_pending     <= 1'b0;
            s1            <= 1'b0;
            s2            <= 1'b0;
            frame_edge    <= 1'b0;
            mask_cnt      <= 2'd0;
            sh_h_total    <= 12'd1650;
            sh_h_sync     <= 12'd40;
            sh_h_bporch   <= 12'd220;
            sh_h_res      <= 12'd1280;
            sh_v_total    <= 12'd750;
            sh_v_sync     <= 12'd5;
            sh_v_bporch   <= 12'd20;
            sh_v_res      <= 12'd720;
            sh_hs_pol     <= 1'b1;
            sh_vs_pol     <= 1'b1;
            sh_r          <= 8'd0;
            sh_g          <= 8'd0;
            sh_b          <= 8'd0;
            sh_mode       <= 3'd0;
            O_h_total     <= 12'd1650;
            O_h_sync      <= 12'd40;
            O_h_bporch    <= 12'd220;
            O_h_res       <= 12'd1280;
            O_v_total     <= 12'd750;
            O_v_sync      <= 12'd5;
            O_v_bporch    <= 12'd20;
            O_v_res       <= 12'd720;
            O_hs_pol      <= 1'b1;
            O_vs_pol      <= 1'b1;
            O_single_r    <= 8'd0;
            O_single_g    <= 8'd0;
            O_single_b    <= 8'd0;
            O_mode        <= 3'd0;
`ifdef TP_SEQ_AUTO_EN
            sh_auto_en    <= 1'b0;
            sh_dwell      <= 8'd0;
            act_auto_en   <= 1'b0;
            act_dwell     <= 8'd0;
            frame_cnt     <= 8'd0;
            step_req      <= 1'b0;
`endif
        end else begin
            O_wr_ack      <= I_wr_en;
            O_commit_done <= 1'b0;
            s1            <= nv;
            s2            <= s1;
            // Edges seen shortly after an active update may be polarity-flip artefacts, not frame starts.
            frame_edge    <= s1 & ~s2 & (mask_cnt == 2'd0);
            if (mask_cnt != 2'd0)
                mask_cnt <= mask_cnt - 2'd1;

            if (I_wr_en) begin
                case (I_wr_addr)
                    4'h0: sh_h_total  <= I_wr_data;
                    4'h1: sh_h_sync   <= I_wr_data;
                    4'h2: sh_h_bporch <= I_wr_data;
                    4'h3: sh_h_res    <= I_wr_data;
                    4'h4: sh_v_total  <= I_wr_data;
                    4'h5: sh_v_sync   <= I_wr_data;
                    4'h6: sh_v_bporch <= I_wr_data;
                    4'h7: sh_v_res    <= I_wr_data;
                    4'h8: {sh_vs_pol, sh_hs_pol} <= I_wr_data[1:0];
                    4'h9: sh_r        <= I_wr_data[7:0];
                    4'hA: sh_g        <= I_wr_data[7:0];
                    4'hB: sh_b        <= I_wr_data[7:0];
                    4'hC: sh_mode     <= I_wr_data[2:0];
`ifdef TP_SEQ_AUTO_EN
                    4'hD: begin
                        sh_auto_en <= I_wr_data[0];
                        sh_dwell   <= I_wr_data[11:4];
                    end
`endif
                    default: ;
                endcase
            end

`ifdef TP_SEQ_AUTO_EN
            step_req <= 1'b0;
            if (frame_edge && act_auto_en && (act_dwell != 8'd0)) begin
                if (frame_cnt + 8'd1 == act_dwell) begin
                    frame_cnt <= 8'd0;
                    step_req  <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
            if (step_req) begin
                O_mode   <= mode_next;
                mask_cnt <= 2'd3;
            end
`endif

            // A passing APPLY comes after the auto-step so the committed mode and counter win.
            case (state)
                ST_RUN: begin
                    if (commit_wr) begin
                        state     <= ST_PEND;
                        O_pending <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (frame_edge) begin
                        state     <= ST_APPLY;
                        O_pending <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    state <= ST_RUN;
                    if (cfg_ok) begin
                        O_h_total     <= sh_h_total;
                        O_h_sync      <= sh_h_sync;
                        O_h_bporch    <= sh_h_bporch;
                        O_h_res       <= sh_h_res;
                        O_v_total     <= sh_v_total;
                        O_v_sync      <= sh_v_sync;
                        O_v_bporch    <= sh_v_bporch;
                        O_v_res       <= sh_v_res;
                        O_hs_pol      <= sh_hs_pol;
                        O_vs_pol      <= sh_vs_pol;
                        O_single_r    <= sh_r;
                        O_single_g    <= sh_g;
                        O_single_b    <= sh_b;
                        O_mode        <= sh_mode;
                        O_commit_done <= 1'b1;
                        O_cfg_err     <= 1'b0;
                        mask_cnt      <= 2'd3;
`ifdef TP_SEQ_AUTO_EN
                        act_auto_en   <= sh_auto_en;
                        act_dwell     <= sh_dwell;
                        frame_cnt     <= 8'd0;
`endif
                    end else begin
                        O_cfg_err <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    O_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
